sgd_data_server: RTL and testbench
==================================

Name: sgd_data_server

Overview:
- Memory-side responder for the SGD trainer's dataset port.
- Holds the initial weight word and the training data points, all loaded by the host.
- During training it serves the word at the trainer's `addr` onto the shared `data` bus.
- When the trainer raises `done`, it releases the bus, captures the trained weights the trainer drives back, and presents them to the host.

Parameters:
- ADDR_WIDTH, 12, width of the trainer address and of the data-point count.
- MAX_FEATURES, 15, maximum features per data point.
- LENGTH, 16, bits per field.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1), width of one word.
- DP, 1024, maximum number of data points; memory depth is DP+1 words.
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with SGD_SERVER_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- host_wr_en  in  1  write the next sequential word
- host_wr_data  in  DATA_WIDTH  word to store
- host_wr_last  in  1  qualifies host_wr_en; marks the final word of the fill
- host_clear  in  1  discard the dataset and return to IDLE
- start  in  1  begin a training run
- addr  in  ADDR_WIDTH  trainer read address
- done  in  1  trainer completion flag
- data  inout  DATA_WIDTH  shared bus with the trainer
- trainer_rst  out  1  reset to the trainer
- data_points  out  ADDR_WIDTH  number of data points loaded
- weights  out  DATA_WIDTH  captured weights W0..W15, W0 in the MSBs
- weights_valid  out  1  weights hold a completed run
- busy  out  1  high in ARM, SERVE and CAPTURE
- overflow  out  1  sticky: a write was dropped because memory was full
- addr_err  out  1  sticky: the trainer addressed beyond data_points

Behaviour:
- Word layout:
  - Word 0 is the initial weight word: W0 in [DATA_WIDTH-1 -: LENGTH], then W1..W15.
  - Words 1..N are data points: Y in the MSB field, then x1..x15 in descending order.
- Reset values:
  - trainer_rst=1.
  - data_points, weights, weights_valid, busy, overflow and addr_err are all 0.
  - data is Z; the write pointer is 0; the state is IDLE.
  - Memory contents are not reset.
- States: IDLE, FILL, ARM, SERVE, CAPTURE, READY.
- IDLE:
  - trainer_rst=1.
  - host_wr_en stores the word at the pointer, increments the pointer and moves to FILL.
  - start is ignored.
- FILL:
  - Each host_wr_en stores the word at the pointer and increments it.
  - When the pointer equals DP+1, further writes are dropped and set overflow.
  - When a write has host_wr_last=1, data_points is set to (pointer after that write) minus 1.
  - start is ignored until a last-write has been seen with data_points>=1.
  - start when enabled goes to ARM.
- ARM:
  - trainer_rst=1 for exactly 2 cycles, then 0, then SERVE.
  - The read register is preloaded with word 0.
- SERVE:
  - data is driven from a read register loaded with mem[addr] every clock (1-cycle latency).
  - If addr > data_points, the register loads all-zeros and addr_err is set.
  - The data output enable is combinationally gated by ~done, so the bus releases in the same cycle done rises (no contention).
  - done=1 moves the state to CAPTURE.
- CAPTURE:
  - One cycle; the bus is not driven by this block.
  - At the end of the cycle, weights is loaded from data, weights_valid=1, then the state moves to READY.
- READY:
  - trainer_rst=0 (the trainer keeps driving its weights), and the bus is not driven.
  - start clears weights_valid and goes to ARM; a re-run uses the same dataset.
- host_clear: from any state, goes to IDLE next clock, clears the pointer, data_points, overflow, addr_err and weights_valid, and sets trainer_rst=1.
- Precedence when several inputs are active in the same cycle: host_clear > start > host_wr_en.
- host_wr_en outside IDLE/FILL is ignored.
- RST mid-run: immediate return to reset values; the bus releases asynchronously.

Optional Feature:
- Macro: SGD_SERVER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in SERVE.
  - If it reaches TIMEOUT_CYCLES without done, the block releases the bus and asserts trainer_rst=1.
  - It then goes to READY with weights_valid=0 and sets an extra sticky output, timeout.
  - The counter clears on entry to ARM.
- Undefined: no counter and no timeout port; SERVE waits indefinitely for done.

Test Plan:
- Reset:
  - Assert RST mid-SERVE, releasing between clock edges.
  - Expect data=Z and trainer_rst=1 at once, all flags 0, state IDLE.
- Fill and count:
  - Write 5 words, the 5th with host_wr_last.
  - Expect data_points=4; start gives trainer_rst=1 for 2 cycles, then 0.
- Serve latency:
  - In SERVE, step addr 0,1,2,3.
  - Expect data equal to word 0,1,2,3 one cycle after each addr.
  - addr=7 yields all-zeros and sets addr_err.
- Turnaround and capture:
  - Trainer model drives done=1 together with weights 0x0001_0002_..._000F_0010 (W0=0x0001 … W15=0x0010).
  - Expect no contention in the done cycle, weights equal to that value, weights_valid=1, state READY.
- Overflow and clear:
  - With DP=4, write 7 words.
  - Expect overflow=1 and data_points=4.
  - host_clear clears everything and returns to IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=20):
  - Hold done=0.
  - Expect timeout=1 after 20 SERVE cycles, weights_valid=0, trainer_rst=1.

Source files
------------

// File: rtl/sgd_data_server_if.sv
// sgd_data_server_if: host fill/control and trainer handshake signals (timeout present with SGD_SERVER_TIMEOUT_EN)
interface sgd_data_server_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 256
);
    logic host_wr_en, host_wr_last, host_clear, start, done;
    logic [DATA_WIDTH-1:0] host_wr_data, weights;
    logic [ADDR_WIDTH-1:0] addr, data_points;
    logic trainer_rst, weights_valid, busy, overflow, addr_err;
`ifdef SGD_SERVER_TIMEOUT_EN
    logic timeout;
    modport slave (
        input host_wr_en, host_wr_data, host_wr_last, host_clear, start, addr, done,
        output trainer_rst, data_points, weights, weights_valid, busy, overflow, addr_err, timeout
    );
    modport master (
        output host_wr_en, host_wr_data, host_wr_last, host_clear, start, addr, done,
        input trainer_rst, data_points, weights, weights_valid, busy, overflow, addr_err, timeout
    );
`else
    modport slave (
        input host_wr_en, host_wr_data, host_wr_last, host_clear, start, addr, done,
        output trainer_rst, data_points, weights, weights_valid, busy, overflow, addr_err
    );
    modport master (
        output host_wr_en, host_wr_data, host_wr_last, host_clear, start, addr, done,
        input trainer_rst, data_points, weights, weights_valid, busy, overflow, addr_err
    );
`endif
endinterface

// File: rtl/sgd_data_server.sv
// sgd_data_server: dataset/weight responder for the SGD trainer; SGD_SERVER_TIMEOUT_EN adds a SERVE watchdog
module sgd_data_server #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH = 16,
    parameter int DATA_WIDTH = LENGTH * (MAX_FEATURES + 1),
    parameter int DP = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic CLK,
    input logic RST,
    inout wire [DATA_WIDTH-1:0] data,
    sgd_data_server_if.slave bus
);
    localparam int PW = $clog2(DP + 2);
    typedef enum logic [2:0] {IDLE, FILL, ARM, SERVE, CAPTURE, READY} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] dp_q, dp_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d, weights_q, weights_d;
    logic wv_q, wv_d, busy_q, busy_d, ovf_q, ovf_d, aerr_q, aerr_d, trst_q, trst_d, arm_q, arm_d;
    logic we, full, start_ok, in_range, expire;
    logic [DATA_WIDTH-1:0] mem [0:DP];
    assign full = ptr_q == PW'(DP + 1);
    assign in_range = bus.addr <= dp_q;
    assign start_ok = bus.start && (state_q == READY || (state_q == FILL && dp_q != '0));
    assign data = (state_q == SERVE && !bus.done) ? rd_q : 'z;
    assign bus.trainer_rst = trst_q;
    assign bus.data_points = dp_q;
    assign bus.weights = weights_q;
    assign bus.weights_valid = wv_q;
    assign bus.busy = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.addr_err = aerr_q;
`ifdef SGD_SERVER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic to_q, to_d;
    assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign bus.timeout = to_q;
    always_comb begin
        cnt_d = state_q == SERVE ? cnt_q + 1'b1 : '0;
        to_d = to_q | (state_q == SERVE && !bus.done && !bus.host_clear && expire);
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            cnt_q <= '0;
            to_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q <= to_d;
        end
`else
    assign expire = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        dp_d = dp_q;
        rd_d = rd_q;
        weights_d = weights_q;
        wv_d = wv_q;
        ovf_d = ovf_q;
        aerr_d = aerr_q;
        trst_d = trst_q;
        arm_d = 1'b0;
        we = 1'b0;
        if (bus.host_clear) begin
            state_d = IDLE;
            ptr_d = '0;
            dp_d = '0;
            ovf_d = 1'b0;
            aerr_d = 1'b0;
            wv_d = 1'b0;
            trst_d = 1'b1;
        end else if (start_ok) begin
            state_d = ARM;
            wv_d = 1'b0;
            trst_d = 1'b1;
        end else if (bus.host_wr_en && (state_q == IDLE || state_q == FILL)) begin
            state_d = FILL;
            we = !full;
            ptr_d = full ? ptr_q : ptr_q + 1'b1;
            ovf_d = ovf_q | full;
            dp_d = bus.host_wr_last ? ADDR_WIDTH'(full ? ptr_q - 1'b1 : ptr_q) : dp_q;
        end else begin
            case (state_q)
                ARM: begin
                    rd_d = mem[0];
                    arm_d = 1'b1;
                    state_d = arm_q ? SERVE : ARM;
                    trst_d = !arm_q;
                end
                SERVE: begin
                    if (bus.done) begin
                        state_d = CAPTURE;
                    end else if (expire) begin
                        state_d = READY;
                        trst_d = 1'b1;
                    end else begin
                        rd_d = in_range ? mem[PW'(bus.addr)] : '0;
                        aerr_d = aerr_q | !in_range;
                    end
                end
                CAPTURE: begin
                    weights_d = data;
                    wv_d = 1'b1;
                    state_d = READY;
                end
                default: ;
            endcase
        end
        busy_d = state_d == ARM || state_d == SERVE || state_d == CAPTURE;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q <= IDLE;
            ptr_q <= '0;
            dp_q <= '0;
            rd_q <= '0;
            weights_q <= '0;
            wv_q <= 1'b0;
            busy_q <= 1'b0;
            ovf_q <= 1'b0;
            aerr_q <= 1'b0;
            trst_q <= 1'b1;
            arm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            dp_q <= dp_d;
            rd_q <= rd_d;
            weights_q <= weights_d;
            wv_q <= wv_d;
            busy_q <= busy_d;
            ovf_q <= ovf_d;
            aerr_q <= aerr_d;
            trst_q <= trst_d;
            arm_q <= arm_d;
        end
    always_ff @(posedge CLK)
        if (we) mem[ptr_q] <= bus.host_wr_data;
endmodule

// File: tb/tb_sgd_data_server.sv
// tb_sgd_data_server: directed bench with DP=4 and TIMEOUT_CYCLES=20
module tb_sgd_data_server;
    localparam int AW = 12;
    localparam int DW = 256;
    localparam logic [DW-1:0] WTS = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010;
    localparam logic [DW-1:0] PROBE = {16{16'h5A3C}};
    logic clk = 1'b0;
    logic rst;
    logic tb_oe;
    logic [DW-1:0] tb_val;
    wire [DW-1:0] data;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    assign data = tb_oe ? tb_val : 'z;
    sgd_data_server_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    sgd_data_server #(.ADDR_WIDTH(AW), .DP(4), .TIMEOUT_CYCLES(20)) dut (
        .CLK(clk), .RST(rst), .data(data), .bus(bus)
    );
    function automatic logic [DW-1:0] word(input int i);
        return {8{32'hC0DE_0000 | 32'(i)}};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic ckw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [DW-1:0] w, input logic last);
        bus.host_wr_en = 1'b1;
        bus.host_wr_data = w;
        bus.host_wr_last = last;
        tick();
        bus.host_wr_en = 1'b0;
        bus.host_wr_last = 1'b0;
    endtask
    task automatic go();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        tb_oe = 1'b0;
        tb_val = '0;
        bus.host_wr_en = 1'b0;
        bus.host_wr_data = '0;
        bus.host_wr_last = 1'b0;
        bus.host_clear = 1'b0;
        bus.start = 1'b0;
        bus.addr = '0;
        bus.done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        ck("reset_trst", 32'(bus.trainer_rst), 1);
        ck("reset_busy", 32'(bus.busy), 0);
        ck("reset_dp", 32'(bus.data_points), 0);
        ck("reset_flags", {29'd0, bus.weights_valid, bus.overflow, bus.addr_err}, 0);
        go();
        ck("idle_start_ignored", 32'(bus.busy), 0);
        for (int i = 0; i < 5; i++) wr(word(i), i == 4);
        ck("fill_dp", 32'(bus.data_points), 4);
        ck("fill_ovf", 32'(bus.overflow), 0);
        go();
        ck("arm1_trst", 32'(bus.trainer_rst), 1);
        ck("arm1_busy", 32'(bus.busy), 1);
        tick();
        ck("arm2_trst", 32'(bus.trainer_rst), 1);
        tick();
        ck("serve_trst", 32'(bus.trainer_rst), 0);
        ckw("serve_preload", data, word(0));
        for (int a = 0; a < 4; a++) begin
            bus.addr = AW'(a);
            tick();
            ckw($sformatf("serve_addr%0d", a), data, word(a));
        end
        ck("no_addr_err", 32'(bus.addr_err), 0);
        bus.addr = 12'd7;
        tick();
        ckw("oob_zero", data, '0);
        ck("oob_addr_err", 32'(bus.addr_err), 1);
        bus.addr = 12'd1;
        tick();
        ckw("pre_done", data, word(1));
        bus.done = 1'b1;
        tb_val = WTS;
        tb_oe = 1'b1;
        #1;
        ckw("done_no_contention", data, WTS);
        tick();
        ck("capture_busy", 32'(bus.busy), 1);
        ckw("capture_bus", data, WTS);
        tick();
        ckw("weights", bus.weights, WTS);
        ck("weights_valid", 32'(bus.weights_valid), 1);
        ck("ready_busy", 32'(bus.busy), 0);
        ck("ready_trst", 32'(bus.trainer_rst), 0);
        go();
        bus.done = 1'b0;
        tb_oe = 1'b0;
        ck("rerun_wv_clear", 32'(bus.weights_valid), 0);
        ck("rerun_trst", 32'(bus.trainer_rst), 1);
        tick();
        tick();
        bus.addr = 12'd2;
        tick();
        ckw("rerun_same_data", data, word(2));
        #2;
        rst = 1'b1;
        #1;
        ck("async_rst_trst", 32'(bus.trainer_rst), 1);
        ck("async_rst_busy", 32'(bus.busy), 0);
        ck("async_rst_flags", {29'd0, bus.weights_valid, bus.overflow, bus.addr_err}, 0);
        ckw("async_rst_weights", bus.weights, '0);
        tb_val = PROBE;
        tb_oe = 1'b1;
        #1;
        ckw("async_rst_release", data, PROBE);
        rst = 1'b0;
        tb_oe = 1'b0;
        tick();
        ck("post_rst_dp", 32'(bus.data_points), 0);
        for (int i = 0; i < 5; i++) wr(word(i + 8), 1'b0);
        ck("full_no_ovf", 32'(bus.overflow), 0);
        wr(word(13), 1'b0);
        ck("ovf_set", 32'(bus.overflow), 1);
        wr(word(14), 1'b1);
        ck("ovf_dp", 32'(bus.data_points), 4);
        go();
        tick();
        tick();
        bus.addr = 12'd4;
        tick();
        ckw("ovf_no_overwrite", data, word(12));
        bus.host_clear = 1'b1;
        tick();
        bus.host_clear = 1'b0;
        ck("clear_dp", 32'(bus.data_points), 0);
        ck("clear_flags", {29'd0, bus.weights_valid, bus.overflow, bus.addr_err}, 0);
        ck("clear_trst", 32'(bus.trainer_rst), 1);
        ck("clear_busy", 32'(bus.busy), 0);
        tb_val = PROBE;
        tb_oe = 1'b1;
        #1;
        ckw("clear_release", data, PROBE);
        tb_oe = 1'b0;
        go();
        ck("clear_start_ignored", 32'(bus.busy), 0);
`ifdef SGD_SERVER_TIMEOUT_EN
        wr(word(20), 1'b0);
        wr(word(21), 1'b1);
        ck("to_dp", 32'(bus.data_points), 1);
        go();
        tick();
        tick();
        ck("to_serve_trst", 32'(bus.trainer_rst), 0);
        repeat (19) tick();
        ck("to_not_yet", 32'(bus.timeout), 0);
        tick();
        ck("to_set", 32'(bus.timeout), 1);
        ck("to_wv", 32'(bus.weights_valid), 0);
        ck("to_trst", 32'(bus.trainer_rst), 1);
        ck("to_busy", 32'(bus.busy), 0);
        tb_val = PROBE;
        tb_oe = 1'b1;
        #1;
        ckw("to_release", data, PROBE);
        tb_oe = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
